id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised, pipelined successor of the MIPS instruction-decode stage. It holds the register file, decodes the write address, write enable and immediate, and registers all decode results into an ID/EX pipeline register. It adds a valid/ready handshake toward EX, load-use hazard stalling, branch flush, and a hardwired-zero R0. It sits between the IF/ID register and EX; write-back arrives from the WB stage.

Parameters:
XLEN, 32, datapath and register width in bits
NREG, 32, number of architectural registers (power of two)
AW, 5, register address width, equal to log2(NREG)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-low
if_valid  in  1  IF/ID holds a valid instruction
if_ins  in  32  instruction word
if_pc  in  XLEN  PC of if_ins
id_ready  out  1  ID accepts if_ins this cycle
flush  in  1  branch redirect; kill the ID/EX contents
wb_we  in  1  write-back enable
wb_adr  in  AW  write-back register address
wb_data  in  XLEN  write-back data
ex_ready  in  1  EX accepts the ID/EX register
ex_valid  out  1  ID/EX register valid
ex_op  out  6  opcode
ex_func  out  6  function field
ex_pc  out  XLEN  PC
ex_rdata1  out  XLEN  rs operand
ex_rdata2  out  XLEN  rt operand
ex_imm  out  XLEN  extended immediate
ex_wadr  out  AW  destination register
ex_we  out  1  destination write enable
ex_is_load  out  1  instruction is LW

Behaviour:
- Reset (RST=0 at a clock edge): every ex_* output is 0 and every REGFILE entry is 0. id_ready is 0 while RST=0.
- Decode fields: op = ins[31:26], func = ins[5:0], rs = ins[25:21], rt = ins[20:16].
- wadr:
  - 31 for JAL.
  - ins[15:11] for R_FORM and JALR.
  - rt otherwise.
- we is 1 for:
  - R_FORM, except func in {JR, MTHI, MTLO, MULT, DIV, DIVU};
  - op 8..15;
  - LW;
  - JAL.
- we is forced to 0 when wadr == 0.
- imm:
  - sign-extend ins[15:0] for ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ, BNE;
  - ins[15:0] shifted left by 16 for LUI;
  - zero-extend for ANDI, ORI, XORI and all others.
  - Width is XLEN; sign-extension replicates ins[15] into bits XLEN-1..16.
- Register file:
  - Write on a clock edge when RST=1, wb_we=1 and wb_adr != 0. Writes to R0 are dropped.
  - R0 always reads 0.
  - Reads are combinational from rs and rt.
- Load-use hazard: hz = ex_valid & ex_is_load & ex_we & (ex_wadr == rs or, for instructions that use rt as a source, ex_wadr == rt), with ex_wadr != 0.
- id_ready = RST & (~ex_valid | ex_ready) & ~hz.
- Priority at each clock edge, highest first:
  1. Reset.
  2. flush: ex_valid <= 0; the IF/ID instruction is not consumed, and id_ready is not asserted while flush=1.
  3. ex_valid & ~ex_ready: hold all ex_*.
  4. hz: insert a bubble (ex_valid <= 0, ex_we <= 0); the instruction stays in IF/ID.
  5. if_valid: load all ex_* from the decode, ex_valid <= 1.
  6. Otherwise ex_valid <= 0.
- Latency: 1 cycle from acceptance to ex_valid. Throughput is 1 per cycle when there is no hazard. A load-use hazard costs exactly one bubble.
- Same-cycle write-back and read of the same register: see Optional Feature. An R0 match never bypasses or stalls.
- Reset asserted mid-stall or mid-hold: reset wins; the pipeline is empty on the following cycle.

Optional Feature:
ID_WB_BYPASS_EN
- Defined: when wb_we=1 and wb_adr equals rs (or rt) and is nonzero, the corresponding rdata sampled into ID/EX is wb_data (write-before-read).
- Undefined: no bypass. A match between wb_adr and a source register counts as an additional hazard term (one-cycle bubble), so the operand is read from REGFILE after the write completes.

Decomposition:
- Package/header common_param: opcode constants R_FORM, JAL, JALR, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW; func constants JR, MTHI, MTLO, MULT, DIV, DIVU; defaults for XLEN and NREG.
- One sub-module, regfile_2r1w: parameters XLEN and NREG, two combinational read ports, one synchronous write port, R0 hardwired to zero, synchronous active-low clear.
- Decode, hazard logic and the pipeline register stay in id_stage_pipe.

Test Plan:
- Reset: drive RST=0 for 2 cycles with if_valid=1 -> ex_valid=0, all ex_*=0, id_ready=0. After release, reading R1..R31 returns 0.
- ADDI: write R2=5 via WB, then issue ADDI r3,r2,0xFFFF -> next cycle ex_valid=1, ex_rdata1=5, ex_imm=0xFFFFFFFF, ex_wadr=3, ex_we=1.
- ORI r4,r0,0x8000 -> ex_imm=0x00008000, ex_rdata1=0. A WB write to R0 of 0xDEAD leaves R0 reading 0. JAL -> ex_wadr=31.
- LW r5 followed by ADD r6,r5,r1 -> exactly one bubble cycle (ex_valid=0, id_ready=0), then the ADD is issued. LW to r5 followed by an unrelated ADD r6,r7,r1 -> no bubble.
- Backpressure and flush: ex_ready=0 for 3 cycles -> ex_* stable and id_ready=0. flush=1 with a valid ID/EX -> ex_valid=0 next cycle, and the IF/ID instruction is still presented afterwards.
- Same-cycle WB to R8=0x1234 while ADD reads r8:
  - with ID_WB_BYPASS_EN -> ex_rdata1=0x1234, no stall;
  - without it -> one bubble, then ex_rdata1=0x1234.

Source files
------------

// File: rtl/common_param.sv
// Shared MIPS decode constants, immediate classification and default widths
// for the instruction-decode stage.
package common_param;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    localparam logic [5:0] R_FORM = 6'h00;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ADDIU  = 6'h09;
    localparam logic [5:0] SLTI   = 6'h0A;
    localparam logic [5:0] SLTIU  = 6'h0B;
    localparam logic [5:0] ANDI   = 6'h0C;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] XORI   = 6'h0E;
    localparam logic [5:0] LUI    = 6'h0F;
    localparam logic [5:0] JALR   = 6'h1F;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;

    localparam logic [5:0] JR     = 6'h08;
    localparam logic [5:0] MTHI   = 6'h11;
    localparam logic [5:0] MTLO   = 6'h13;
    localparam logic [5:0] MULT   = 6'h18;
    localparam logic [5:0] DIV    = 6'h1A;
    localparam logic [5:0] DIVU   = 6'h1B;

    typedef enum logic [1:0] {
        IMM_ZERO,
        IMM_SIGN,
        IMM_UPPER
    } imm_kind_e;

    function automatic imm_kind_e imm_kind(input logic [5:0] op);
        case (op)
            ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ, BNE: return IMM_SIGN;
            LUI:                                        return IMM_UPPER;
            default:                                    return IMM_ZERO;
        endcase
    endfunction

    // Instructions whose rt field names a source operand rather than a destination.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == R_FORM) || (op == BEQ) || (op == BNE) || (op == SW);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two combinational read ports, one synchronous write port, R0 hardwired to
// zero, synchronous active-low clear of every entry.
module regfile_2r1w #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wadr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_radr1,
    input  logic [AW-1:0]   i_radr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_mem [NREG];

    // NOTE: the array is cleared on reset because software relies on zeroed
    // registers; this costs a reset net on every bit, so it is not a RAM macro.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wadr != '0)) begin
            r_mem[i_wadr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_radr1 == '0) ? '0 : r_mem[i_radr1];
    assign o_rdata2 = (i_radr2 == '0) ? '0 : r_mem[i_radr2];

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined MIPS decode stage: register file, decode, load-use/flush control
// and the ID/EX register. Define ID_WB_BYPASS_EN to forward same-cycle WB data.
module id_stage_pipe
    import common_param::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            if_valid,
    input  logic [31:0]     if_ins,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_adr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [5:0]      ex_op,
    output logic [5:0]      ex_func,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rdata1,
    output logic [XLEN-1:0] ex_rdata2,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_wadr,
    output logic            ex_we,
    output logic            ex_is_load
);

    logic [5:0]      w_op, w_func;
    logic [AW-1:0]   w_rs, w_rt, w_rd, w_wadr;
    logic            w_we, w_rt_src, w_load_use, w_wb_hz, w_hz;
    logic [XLEN-1:0] w_imm, w_rf_rdata1, w_rf_rdata2, w_rdata1, w_rdata2;

    logic            r_ex_valid, r_ex_we, r_ex_is_load;
    logic [5:0]      r_ex_op, r_ex_func;
    logic [XLEN-1:0] r_ex_pc, r_ex_rdata1, r_ex_rdata2, r_ex_imm;
    logic [AW-1:0]   r_ex_wadr;

    assign w_op     = if_ins[31:26];
    assign w_func   = if_ins[5:0];
    assign w_rs     = AW'(if_ins[25:21]);
    assign w_rt     = AW'(if_ins[20:16]);
    assign w_rd     = AW'(if_ins[15:11]);
    assign w_rt_src = uses_rt(w_op);

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_we     (wb_we),
        .i_wadr   (wb_adr),
        .i_wdata  (wb_data),
        .i_radr1  (w_rs),
        .i_radr2  (w_rt),
        .o_rdata1 (w_rf_rdata1),
        .o_rdata2 (w_rf_rdata2)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_wadr = w_rt;
        w_we   = 1'b0;
        w_imm  = {{(XLEN-16){1'b0}}, if_ins[15:0]};
        case (w_op)
            R_FORM: begin
                w_wadr = w_rd;
                w_we   = !(w_func inside {JR, MTHI, MTLO, MULT, DIV, DIVU});
            end
            JALR:    w_wadr = w_rd;
            JAL: begin
                w_wadr = AW'(31);
                w_we   = 1'b1;
            end
            LW:      w_we = 1'b1;
            default: w_we = (w_op[5:3] == 3'b001);
        endcase
        case (imm_kind(w_op))
            IMM_SIGN:  w_imm = {{(XLEN-16){if_ins[15]}}, if_ins[15:0]};
            IMM_UPPER: w_imm = XLEN'({if_ins[15:0], 16'h0000});
            default:   ;
        endcase
        if (w_wadr == '0) begin
            w_we = 1'b0;
        end
    end

    assign w_load_use = r_ex_valid && r_ex_is_load && r_ex_we && (r_ex_wadr != '0) &&
                        ((r_ex_wadr == w_rs) || (w_rt_src && (r_ex_wadr == w_rt)));

`ifdef ID_WB_BYPASS_EN
    assign w_wb_hz  = 1'b0;
    assign w_rdata1 = (wb_we && (wb_adr != '0) && (wb_adr == w_rs)) ? wb_data : w_rf_rdata1;
    assign w_rdata2 = (wb_we && (wb_adr != '0) && (wb_adr == w_rt)) ? wb_data : w_rf_rdata2;
`else
    // Without forwarding, wait one cycle so the operand comes from the written entry.
    assign w_wb_hz  = wb_we && (wb_adr != '0) &&
                      ((wb_adr == w_rs) || (w_rt_src && (wb_adr == w_rt)));
    assign w_rdata1 = w_rf_rdata1;
    assign w_rdata2 = w_rf_rdata2;
`endif

    assign w_hz     = w_load_use || w_wb_hz;
    assign id_ready = RST && !flush && (!r_ex_valid || ex_ready) && !w_hz;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_ex_valid   <= 1'b0;
            r_ex_op      <= '0;
            r_ex_func    <= '0;
            r_ex_pc      <= '0;
            r_ex_rdata1  <= '0;
            r_ex_rdata2  <= '0;
            r_ex_imm     <= '0;
            r_ex_wadr    <= '0;
            r_ex_we      <= 1'b0;
            r_ex_is_load <= 1'b0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (r_ex_valid && !ex_ready) begin
            // EX is stalled: ID/EX keeps its contents.
        end else if (w_hz) begin
            r_ex_valid <= 1'b0;
            r_ex_we    <= 1'b0;
        end else if (if_valid) begin
            r_ex_valid   <= 1'b1;
            r_ex_op      <= w_op;
            r_ex_func    <= w_func;
            r_ex_pc      <= if_pc;
            r_ex_rdata1  <= w_rdata1;
            r_ex_rdata2  <= w_rdata2;
            r_ex_imm     <= w_imm;
            r_ex_wadr    <= w_wadr;
            r_ex_we      <= w_we;
            r_ex_is_load <= (w_op == LW);
        end else begin
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_op      = r_ex_op;
    assign ex_func    = r_ex_func;
    assign ex_pc      = r_ex_pc;
    assign ex_rdata1  = r_ex_rdata1;
    assign ex_rdata2  = r_ex_rdata2;
    assign ex_imm     = r_ex_imm;
    assign ex_wadr    = r_ex_wadr;
    assign ex_we      = r_ex_we;
    assign ex_is_load = r_ex_is_load;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed steps then random traffic,
// all compared against a cycle-level reference model of the decode stage.
module tb_id_stage_pipe;
    import common_param::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            CLK = 1'b0;
    logic            RST, if_valid, flush, wb_we, ex_ready;
    logic [31:0]     if_ins;
    logic [XLEN-1:0] if_pc, wb_data;
    logic [AW-1:0]   wb_adr;
    logic            id_ready, ex_valid, ex_we, ex_is_load;
    logic [5:0]      ex_op, ex_func;
    logic [XLEN-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [AW-1:0]   ex_wadr;

    id_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_func(ex_func), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm(ex_imm), .ex_wadr(ex_wadr), .ex_we(ex_we), .ex_is_load(ex_is_load)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        valid;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  wadr;
        logic        we;
        logic        load;
    } idex_t;

    typedef struct {
        logic [4:0]  wadr;
        logic        we;
        logic [31:0] imm;
        logic        load;
        logic        rt_src;
    } dec_t;

    idex_t       m;
    logic [31:0] m_regs [32];
    logic        acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == JAL)                        d.wadr = 5'd31;
        else if (op == R_FORM || op == JALR)  d.wadr = ins[15:11];
        else                                  d.wadr = ins[20:16];
        d.we = (op == R_FORM && !(fn inside {JR, MTHI, MTLO, MULT, DIV, DIVU})) ||
               (op >= 6'd8 && op <= 6'd15) || op == LW || op == JAL;
        if (d.wadr == 5'd0) d.we = 1'b0;
        d.imm = {16'h0000, ins[15:0]};
        if (op inside {ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ, BNE}) begin
            if (ins[15]) d.imm = d.imm - 32'h0001_0000;
        end else if (op == LUI) begin
            d.imm = d.imm * 32'd65536;
        end
        d.load   = (op == LW);
        d.rt_src = op inside {R_FORM, BEQ, BNE, SW};
        return d;
    endfunction

    task automatic model_clear();
        m.valid = 0; m.op = 0; m.func = 0; m.pc = 0; m.rd1 = 0;
        m.rd2 = 0; m.imm = 0; m.wadr = 0; m.we = 0; m.load = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
    endtask

    // One clock: check id_ready, advance the model, then check the ID/EX outputs.
    task automatic tick(output logic accepted);
        dec_t        d;
        logic [4:0]  rs, rt;
        logic        hz, exp_ready;
        logic [31:0] v1, v2;
        #1;
        d  = decode(if_ins);
        rs = if_ins[25:21];
        rt = if_ins[20:16];
        hz = m.valid && m.load && m.we && m.wadr != 0 &&
             (m.wadr == rs || (d.rt_src && m.wadr == rt));
        v1 = m_regs[rs];
        v2 = m_regs[rt];
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_adr != 0 && wb_adr == rs) v1 = wb_data;
        if (wb_we && wb_adr != 0 && wb_adr == rt) v2 = wb_data;
`else
        if (wb_we && wb_adr != 0 && (wb_adr == rs || (d.rt_src && wb_adr == rt))) hz = 1;
`endif
        exp_ready = RST && !flush && (!m.valid || ex_ready) && !hz;
        check("id_ready", 32'(id_ready), 32'(exp_ready));
        accepted = exp_ready && if_valid;
        if (!RST) begin
            model_clear();
        end else begin
            if (flush) m.valid = 0;
            else if (m.valid && !ex_ready) m.valid = 1;
            else if (hz) begin m.valid = 0; m.we = 0; end
            else if (if_valid) begin
                m.valid = 1; m.op = if_ins[31:26]; m.func = if_ins[5:0]; m.pc = if_pc;
                m.rd1 = v1; m.rd2 = v2; m.imm = d.imm; m.wadr = d.wadr;
                m.we = d.we; m.load = d.load;
            end else m.valid = 0;
            if (wb_we && wb_adr != 0) m_regs[wb_adr] = wb_data;
        end
        @(posedge CLK);
        #1;
        check("ex_valid", 32'(ex_valid), 32'(m.valid));
        check("ex_op", 32'(ex_op), 32'(m.op));
        check("ex_func", 32'(ex_func), 32'(m.func));
        check("ex_pc", ex_pc, m.pc);
        check("ex_rdata1", ex_rdata1, m.rd1);
        check("ex_rdata2", ex_rdata2, m.rd2);
        check("ex_imm", ex_imm, m.imm);
        check("ex_wadr", 32'(ex_wadr), 32'(m.wadr));
        check("ex_we", 32'(ex_we), 32'(m.we));
        check("ex_is_load", 32'(ex_is_load), 32'(m.load));
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] ins;
        logic [5:0]  op;
        ins = $urandom;
        case ($urandom_range(0, 15))
            0, 1: op = R_FORM;
            2:  op = JAL;
            3:  op = JALR;
            4:  op = BEQ;
            5:  op = BNE;
            6:  op = ADDI;
            7:  op = ADDIU;
            8:  op = SLTI;
            9:  op = ANDI;
            10: op = ORI;
            11: op = LUI;
            12, 13: op = LW;
            14: op = SW;
            default: op = 6'h3F;
        endcase
        ins[31:26] = op;
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        if (op == R_FORM) begin
            ins[15:11] = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: ins[5:0] = JR;
                1: ins[5:0] = MTHI;
                2: ins[5:0] = MULT;
                3: ins[5:0] = DIVU;
                default: ins[5:0] = 6'h20;
            endcase
        end
        return ins;
    endfunction

    initial begin
        model_clear();
        RST = 0; if_valid = 1; if_ins = {ADDI, 5'd2, 5'd3, 16'hFFFF}; if_pc = 32'h100;
        flush = 0; wb_we = 0; wb_adr = 0; wb_data = 0; ex_ready = 1;

        // Reset with a valid instruction offered.
        repeat (2) tick(acc);
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_ex_pc", ex_pc, 0);
        check("rst_id_ready", 32'(id_ready), 0);
        RST = 1;

        // Every register reads zero after reset.
        for (int i = 1; i < 32; i += 2) begin
            if_ins = {R_FORM, 5'(i), 5'(i + 1), 5'd1, 5'd0, 6'h20};
            if_pc  = 32'h200 + 32'(4 * i);
            tick(acc);
            check("rf_clear_rs", ex_rdata1, 0);
            check("rf_clear_rt", ex_rdata2, 0);
        end

        // ADDI r3,r2,0xFFFF after writing R2=5.
        if_valid = 0; wb_we = 1; wb_adr = 2; wb_data = 5;
        tick(acc);
        wb_we = 0; if_valid = 1; if_ins = {ADDI, 5'd2, 5'd3, 16'hFFFF}; if_pc = 32'h280;
        tick(acc);
        check("addi_valid", 32'(ex_valid), 1);
        check("addi_rdata1", ex_rdata1, 5);
        check("addi_imm", ex_imm, 32'hFFFF_FFFF);
        check("addi_wadr", 32'(ex_wadr), 3);
        check("addi_we", 32'(ex_we), 1);

        // ORI zero-extends; a WB to R0 is dropped; JAL targets R31.
        if_ins = {ORI, 5'd0, 5'd4, 16'h8000}; wb_we = 1; wb_adr = 0; wb_data = 32'hDEAD;
        tick(acc);
        wb_we = 0;
        check("ori_imm", ex_imm, 32'h0000_8000);
        check("ori_rdata1", ex_rdata1, 0);
        if_ins = {R_FORM, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20};
        tick(acc);
        check("r0_rdata1", ex_rdata1, 0);
        check("r0_rdata2", ex_rdata2, 0);
        if_ins = {JAL, 26'h000_0040};
        tick(acc);
        check("jal_wadr", 32'(ex_wadr), 31);
        check("jal_we", 32'(ex_we), 1);

        // Load-use: exactly one bubble; unrelated consumer: none.
        if_ins = {LW, 5'd1, 5'd5, 16'h0004};
        tick(acc);
        check("lw_is_load", 32'(ex_is_load), 1);
        if_ins = {R_FORM, 5'd5, 5'd1, 5'd6, 5'd0, 6'h20};
        #1 check("lu_id_ready", 32'(id_ready), 0);
        tick(acc);
        check("lu_bubble", 32'(ex_valid), 0);
        tick(acc);
        check("lu_issue_valid", 32'(ex_valid), 1);
        check("lu_issue_wadr", 32'(ex_wadr), 6);
        if_ins = {LW, 5'd1, 5'd5, 16'h0008};
        tick(acc);
        if_ins = {R_FORM, 5'd7, 5'd1, 5'd6, 5'd0, 6'h20};
        tick(acc);
        check("nolu_valid", 32'(ex_valid), 1);
        check("nolu_op", 32'(ex_op), 32'(R_FORM));

        // Backpressure for three cycles.
        if_ins = {ADDI, 5'd2, 5'd11, 16'h0010}; if_pc = 32'h300;
        tick(acc);
        ex_ready = 0; if_ins = {ORI, 5'd2, 5'd12, 16'h0001}; if_pc = 32'h304;
        repeat (3) begin
            #1 check("bp_id_ready", 32'(id_ready), 0);
            tick(acc);
            check("bp_valid", 32'(ex_valid), 1);
            check("bp_pc", ex_pc, 32'h300);
            check("bp_imm", ex_imm, 32'h10);
            check("bp_rdata1", ex_rdata1, 5);
        end
        ex_ready = 1;
        tick(acc);
        check("bp_release_pc", ex_pc, 32'h304);

        // Flush kills ID/EX and leaves the IF/ID instruction pending.
        if_ins = {XORI, 5'd2, 5'd13, 16'h00F0}; if_pc = 32'h308; flush = 1;
        #1 check("fl_id_ready", 32'(id_ready), 0);
        tick(acc);
        check("fl_valid", 32'(ex_valid), 0);
        flush = 0;
        tick(acc);
        check("fl_after_valid", 32'(ex_valid), 1);
        check("fl_after_pc", ex_pc, 32'h308);

        // Same-cycle write-back of R8 while an ADD reads it.
        if_ins = {R_FORM, 5'd8, 5'd0, 5'd10, 5'd0, 6'h20}; if_pc = 32'h30C;
        wb_we = 1; wb_adr = 8; wb_data = 32'h1234;
        tick(acc);
        wb_we = 0;
`ifdef ID_WB_BYPASS_EN
        check("wb_byp_valid", 32'(ex_valid), 1);
        check("wb_byp_rdata1", ex_rdata1, 32'h1234);
`else
        check("wb_stall_valid", 32'(ex_valid), 0);
        tick(acc);
        check("wb_after_valid", 32'(ex_valid), 1);
        check("wb_after_rdata1", ex_rdata1, 32'h1234);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if (acc || !if_valid) begin
                if_valid = ($urandom_range(0, 3) != 0);
                if_ins   = rand_ins();
                if_pc    = $urandom & 32'hFFFF_FFFC;
            end
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            RST      = ($urandom_range(0, 99) != 0);
            wb_we    = ($urandom_range(0, 2) == 0);
            wb_adr   = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            tick(acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
